// File: rtl/ram_block_be_pipelined.sv
// ram_block_be_pipelined
//   True dual-port synchronous RAM on a single clock with per-byte write
//   enables, a parameterised registered read latency, and per-port read-valid.
//   Port 0 has priority on overlapping write bytes; such overlaps raise a
//   one-cycle collision pulse. Reads are read-first against the other port.
//
// Parameters
//   DWIDTH        data width (multiple of 8)
//   AWIDTH        address width
//   MEM_SIZE      number of words (<= 2**AWIDTH)
//   READ_LATENCY  cycles from accepted read to q/rvalid (1..8)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   addrN, ceN, weN       port N address, enable, write(1)/read(0)
//   beN, dN               port N byte enables and write data
//   qN, rvalidN           port N read data (held when rvalidN=0) and valid
//   collision             write-write byte overlap, one cycle after the writes
//   busy                  RAM unavailable (clear sequence), accesses ignored
//
// Optional feature
//   RAM_BLOCK_BE_CLEAR_EN: reset starts a MEM_SIZE-cycle zero-fill of the RAM,
//   during which busy=1. Without it busy is tied low and reset leaves the RAM
//   contents alone.
module ram_block_be_pipelined #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 13,
  parameter int MEM_SIZE     = 3072,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AWIDTH-1:0]     addr0,
  input  logic                  ce0,
  input  logic                  we0,
  input  logic [DWIDTH/8-1:0]   be0,
  input  logic [DWIDTH-1:0]     d0,
  output logic [DWIDTH-1:0]     q0,
  output logic                  rvalid0,
  input  logic [AWIDTH-1:0]     addr1,
  input  logic                  ce1,
  input  logic                  we1,
  input  logic [DWIDTH/8-1:0]   be1,
  input  logic [DWIDTH-1:0]     d1,
  output logic [DWIDTH-1:0]     q1,
  output logic                  rvalid1,
  output logic                  collision,
  output logic                  busy
);

  localparam int BEW = DWIDTH / 8;
  localparam int IW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(MEM_SIZE);

  logic [DWIDTH-1:0] mem_q [MEM_SIZE];

  logic [AWIDTH-1:0] addr_w [2];
  logic [BEW-1:0]    be_w   [2];
  logic [DWIDTH-1:0] d_w    [2];
  logic [DWIDTH-1:0] rd_data [2];
  logic [1:0]        ce_w, we_w, in_rng, rd_acc, wr_acc;
  logic              collision_q;

  assign addr_w[0] = addr0;
  assign addr_w[1] = addr1;
  assign be_w[0]   = be0;
  assign be_w[1]   = be1;
  assign d_w[0]    = d0;
  assign d_w[1]    = d1;
  assign ce_w      = {ce1, ce0};
  assign we_w      = {we1, we0};

  // ---------------------------------------------------------------------------
  // Optional clear sequencer
  // ---------------------------------------------------------------------------
`ifdef RAM_BLOCK_BE_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IW'(MEM_SIZE - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state_q == CLEAR);
`else
  assign busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Access decode and array read (read-first: old word is sampled here)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_rng = '0;
    rd_acc = '0;
    wr_acc = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      in_rng[p]  = ({1'b0, addr_w[p]} < DEPTH);
      if (ce_w[p] && !busy) begin
        rd_acc[p] = !we_w[p];
        wr_acc[p] = we_w[p] && in_rng[p];
      end
      if (in_rng[p]) rd_data[p] = mem_q[addr_w[p][IW-1:0]];
    end
  end

  // Port 1 bytes are written first so port 0 overrides them on overlap.
  always_ff @(posedge clk) begin
`ifdef RAM_BLOCK_BE_CLEAR_EN
    if (clr_we) mem_q[cnt_q] <= '0;
`endif
    for (int unsigned b = 0; b < BEW; b++) begin
      if (wr_acc[1] && be_w[1][b]) mem_q[addr_w[1][IW-1:0]][8*b +: 8] <= d_w[1][8*b +: 8];
    end
    for (int unsigned b = 0; b < BEW; b++) begin
      if (wr_acc[0] && be_w[0][b]) mem_q[addr_w[0][IW-1:0]][8*b +: 8] <= d_w[0][8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= wr_acc[0] && wr_acc[1] && (addr0 == addr1) && (|(be0 & be1));
  end

  assign collision = collision_q;

  // ---------------------------------------------------------------------------
  // Read pipelines: inner stages shift freely; the last stage only loads on a
  // valid so q holds between reads.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [READ_LATENCY-1:0] vld_q;
    logic [DWIDTH-1:0]       dat_q [READ_LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int unsigned k = 0; k < READ_LATENCY; k++) dat_q[k] <= '0;
      end else begin
        vld_q[0] <= rd_acc[p];
        if (READ_LATENCY > 1 || rd_acc[p]) dat_q[0] <= rd_data[p];
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
          vld_q[k] <= vld_q[k-1];
          if (k < READ_LATENCY - 1 || vld_q[k-1]) dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign q0      = g_port[0].dat_q[READ_LATENCY-1];
  assign rvalid0 = g_port[0].vld_q[READ_LATENCY-1];
  assign q1      = g_port[1].dat_q[READ_LATENCY-1];
  assign rvalid1 = g_port[1].vld_q[READ_LATENCY-1];

endmodule
